actuador_persiana: RTL and testbench

ACTUADOR_PERSIANA -- requirements
Module: actuador_persiana

---
 rtl/actuador_persiana.sv | 143 ++++++++++++++
 tb/tb_actuador_persiana.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/actuador_persiana.sv
// Behavioural blind actuator: motor FSM with dead-time on reversal, stall
// detection on obstruction, and position sensors decoded from the position.
module actuador_persiana #(
    parameter logic [24:0] TICK_DIV    = 25'd16777216,
    parameter logic [6:0]  POS_MAX     = 7'd100,
    parameter logic [6:0]  POS_MED     = 7'd50,
    parameter logic [6:0]  SENS_WIN    = 7'd2,
    parameter int          DEAD_TICKS  = 3,
    parameter int          STALL_TICKS = 4
) (
    input  logic       clk,
    input  logic       reseteo,
    input  logic       subir,
    input  logic       bajar,
    input  logic       bloqueo,
    output logic       Ssup,
    output logic       Smed,
    output logic       Sinf,
    output logic [6:0] posicion,
    output logic       moviendo,
    output logic       falla
);

    typedef enum logic [2:0] {
        REPOSO,
        SUBIENDO,
        BAJANDO,
        PAUSA,
        FALLA
    } estado_t;

    localparam logic [24:0] TICK_LAST = TICK_DIV - 25'd1;
    localparam logic [7:0]  DEAD_LIM  = 8'(DEAD_TICKS);
    localparam logic [7:0]  STALL_LIM = 8'(STALL_TICKS);
    localparam logic [6:0]  MED_LO    = POS_MED - SENS_WIN;
    localparam logic [6:0]  MED_HI    = POS_MED + SENS_WIN;

    estado_t     state_reg, state_next;
    logic [6:0]  pos_reg, pos_next;
    logic [24:0] tick_cnt_reg, tick_cnt_next;
    logic [7:0]  stall_reg, stall_next;
    logic [7:0]  dead_reg, dead_next;
    logic        tick;

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            state_reg    <= REPOSO;
            pos_reg      <= 7'd0;
            tick_cnt_reg <= 25'd0;
            stall_reg    <= 8'd0;
            dead_reg     <= 8'd0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            tick_cnt_reg <= tick_cnt_next;
            stall_reg    <= stall_next;
            dead_reg     <= dead_next;
        end
    end

    assign tick          = (tick_cnt_reg == TICK_LAST);
    assign tick_cnt_next = tick ? 25'd0 : tick_cnt_reg + 25'd1;

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        stall_next = stall_reg;
        dead_next  = dead_reg;

        // Conflicting commands are a controller fault wherever we are.
        if (state_reg != FALLA && subir && bajar) begin
            state_next = FALLA;
        end else begin
            case (state_reg)
                REPOSO: begin
                    stall_next = 8'd0;
                    dead_next  = 8'd0;
                    if (subir && !bajar && pos_reg < POS_MAX) begin
                        state_next = SUBIENDO;
                    end else if (bajar && !subir && pos_reg != 7'd0) begin
                        state_next = BAJANDO;
                    end
                end
                SUBIENDO: begin
                    if (!subir) begin
                        stall_next = 8'd0;
                        dead_next  = 8'd0;
                        state_next = bajar ? PAUSA : REPOSO;
                    end else if (tick) begin
                        if (bloqueo) begin
                            stall_next = stall_reg + 8'd1;
                            if (stall_reg + 8'd1 >= STALL_LIM) state_next = FALLA;
                        end else begin
                            stall_next = 8'd0;
                            if (pos_reg < POS_MAX) pos_next = pos_reg + 7'd1;
                            if (pos_reg >= POS_MAX - 7'd1) state_next = REPOSO;
                        end
                    end
                end
                BAJANDO: begin
                    if (!bajar) begin
                        stall_next = 8'd0;
                        dead_next  = 8'd0;
                        state_next = subir ? PAUSA : REPOSO;
                    end else if (tick) begin
                        if (bloqueo) begin
                            stall_next = stall_reg + 8'd1;
                            if (stall_reg + 8'd1 >= STALL_LIM) state_next = FALLA;
                        end else begin
                            stall_next = 8'd0;
                            if (pos_reg != 7'd0) pos_next = pos_reg - 7'd1;
                            if (pos_reg <= 7'd1) state_next = REPOSO;
                        end
                    end
                end
                PAUSA: begin
                    if (tick) begin
                        if (dead_reg + 8'd1 >= DEAD_LIM) begin
                            dead_next  = 8'd0;
                            state_next = REPOSO;
                        end else begin
                            dead_next = dead_reg + 8'd1;
                        end
                    end
                end
                FALLA: begin
                    state_next = FALLA;
                end
                default: begin
                    state_next = REPOSO;
                end
            endcase
        end
    end

    assign posicion = pos_reg;
    assign Ssup     = (pos_reg == POS_MAX);
    assign Sinf     = (pos_reg == 7'd0);
    assign Smed     = (pos_reg >= MED_LO) && (pos_reg <= MED_HI);
    assign moviendo = (state_reg == SUBIENDO) || (state_reg == BAJANDO);
    assign falla    = (state_reg == FALLA);

endmodule

// File: tb/tb_actuador_persiana.sv
// Directed vector table plus randomized run against a rule-level model of
// the blind actuator, using small parameters so motion is fast.
module tb_actuador_persiana;

    localparam int TDIV  = 4;
    localparam int PMAX  = 10;
    localparam int DEAD  = 2;
    localparam int STALL = 3;

    logic       clk;
    logic       reseteo;
    logic       subir, bajar, bloqueo;
    logic       Ssup, Smed, Sinf, moviendo, falla;
    logic [6:0] posicion;

    int n_checks = 0;
    int n_fail   = 0;

    actuador_persiana #(
        .TICK_DIV(25'd4), .POS_MAX(7'd10), .POS_MED(7'd5), .SENS_WIN(7'd1),
        .DEAD_TICKS(2), .STALL_TICKS(3)
    ) dut (
        .clk(clk), .reseteo(reseteo), .subir(subir), .bajar(bajar),
        .bloqueo(bloqueo), .Ssup(Ssup), .Smed(Smed), .Sinf(Sinf),
        .posicion(posicion), .moviendo(moviendo), .falla(falla)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst, su, ba, bl;
        int cyc;
        int pos;
        bit mov, fal, ssup, smed, sinf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit su, bit ba, bit bl, int cyc, int pos,
                                bit mov, bit fal, bit ssup, bit smed, bit sinf);
        vec_t v;
        v.rst = rst; v.su = su; v.ba = ba; v.bl = bl; v.cyc = cyc; v.pos = pos;
        v.mov = mov; v.fal = fal; v.ssup = ssup; v.smed = smed; v.sinf = sinf;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int status();
        return int'({moviendo, falla, Ssup, Smed, Sinf});
    endfunction

    // Rule-level model: one "moving" mode with a direction instead of two states.
    localparam int M_IDLE = 0, M_MOVE = 1, M_PAUSE = 2, M_FAULT = 3;
    int m_mode, m_pos, m_cnt, m_stall, m_dead, m_dir;

    task automatic mdl_reset();
        m_mode = M_IDLE; m_pos = 0; m_cnt = 0; m_stall = 0; m_dead = 0; m_dir = 0;
    endtask

    task automatic mdl_step(input bit su, input bit ba, input bit bl);
        bit tk, keep, rev;
        tk    = (m_cnt == TDIV - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        keep  = (m_dir > 0) ? su : ba;
        rev   = (m_dir > 0) ? ba : su;
        if (m_mode != M_FAULT && su && ba) begin
            m_mode = M_FAULT;
        end else if (m_mode == M_IDLE) begin
            m_stall = 0;
            if (su && !ba && m_pos < PMAX) begin
                m_mode = M_MOVE; m_dir = 1;
            end else if (ba && !su && m_pos > 0) begin
                m_mode = M_MOVE; m_dir = -1;
            end
        end else if (m_mode == M_MOVE) begin
            if (!keep) begin
                m_mode  = rev ? M_PAUSE : M_IDLE;
                m_stall = 0;
                m_dead  = 0;
            end else if (tk) begin
                if (bl) begin
                    m_stall++;
                    if (m_stall >= STALL) m_mode = M_FAULT;
                end else begin
                    m_stall = 0;
                    m_pos   = m_pos + m_dir;
                    if (m_pos < 0) m_pos = 0;
                    if (m_pos > PMAX) m_pos = PMAX;
                    if (m_pos == 0 || m_pos == PMAX) m_mode = M_IDLE;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (tk) begin
                m_dead++;
                if (m_dead >= DEAD) begin
                    m_mode = M_IDLE; m_dead = 0;
                end
            end
        end
    endtask

    function automatic int mdl_status();
        bit mv, fl, su, sm, si;
        mv = (m_mode == M_MOVE);
        fl = (m_mode == M_FAULT);
        su = (m_pos == PMAX);
        sm = (m_pos >= 4) && (m_pos <= 6);
        si = (m_pos == 0);
        return int'({mv, fl, su, sm, si});
    endfunction

    initial begin
        int cmd, fault_cyc, c;
        bit su, ba, bl;

        //         rst su ba bl cyc pos mov fal sup med inf
        vecs.push_back(mk(1, 1, 0, 0,  1,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 15,  4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  8,  6, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 12, 10, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  8, 10, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0,  4,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 12,  3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  1,  3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  7,  3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  1,  3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  3,  2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  8,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  4,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  6,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  5,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  8,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  8,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1,  1,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 10,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1,  1,  0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1,  8,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  4,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4,  2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24,  6, 1, 0, 0, 1, 0));

        reseteo = 1'b1; subir = 1'b0; bajar = 1'b0; bloqueo = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pos", int'(posicion), 0);
        chk("reset_status", status(), int'(5'b00001));

        // Table: inputs held for cyc rising edges, outputs checked on the next falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) reseteo = 1'b1;
            subir = vecs[i].su; bajar = vecs[i].ba; bloqueo = vecs[i].bl;
            #2 reseteo = 1'b0;
            repeat (vecs[i].cyc) @(posedge clk);
            @(negedge clk);
            $display("vec%0d su=%0b ba=%0b bl=%0b cyc=%0d -> pos=%0d status=%05b",
                     i, vecs[i].su, vecs[i].ba, vecs[i].bl, vecs[i].cyc, posicion, status());
            chk($sformatf("vec%0d_pos", i), int'(posicion), vecs[i].pos);
            chk($sformatf("vec%0d_status", i), status(),
                int'({vecs[i].mov, vecs[i].fal, vecs[i].ssup, vecs[i].smed, vecs[i].sinf}));
        end

        // Asynchronous reset mid-rise at position 6, observed before any clock edge.
        #1 reseteo = 1'b1;
        #1;
        chk("async_rst_pos", int'(posicion), 0);
        chk("async_rst_status", status(), int'(5'b00001));
        reseteo = 1'b0;

        // Reset out of FALLA clears the fault without a clock edge.
        @(negedge clk);
        subir = 1'b1; bajar = 1'b1;
        @(negedge clk);
        chk("fault_set", int'(falla), 1);
        subir = 1'b0; bajar = 1'b0;
        #1 reseteo = 1'b1;
        #1;
        chk("fault_clear_async", int'(falla), 0);
        reseteo = 1'b0;

        // Randomized run against the model.
        @(negedge clk);
        reseteo = 1'b1; #1 reseteo = 1'b0;
        mdl_reset();
        cmd = 0; fault_cyc = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_mode == M_FAULT) fault_cyc++;
            if (fault_cyc > 12 || $urandom_range(0, 799) == 0) begin
                reseteo = 1'b1; #1 reseteo = 1'b0;
                mdl_reset();
                fault_cyc = 0;
            end
            if ($urandom_range(0, 7) == 0) cmd = int'($urandom_range(0, 2));
            c  = ($urandom_range(0, 299) == 0) ? 3 : cmd;
            su = (c == 1) || (c == 3);
            ba = (c == 2) || (c == 3);
            bl = ($urandom_range(0, 99) < 12);
            subir = su; bajar = ba; bloqueo = bl;
            @(posedge clk);
            mdl_step(su, ba, bl);
            @(negedge clk);
            $display("rnd%0d su=%0b ba=%0b bl=%0b -> pos=%0d status=%05b", n, su, ba, bl,
                     posicion, status());
            chk($sformatf("rnd%0d_pos", n), int'(posicion), m_pos);
            chk($sformatf("rnd%0d_status", n), status(), mdl_status());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
